// File: rtl/soc_instr_pkg.sv
// Shared definitions for the HPS instruction receiver.
// Contents: opcode constants, status bit indices, instruction field
// positions, FSM state encoding and the size-code decode helper.
package soc_instr_pkg;

  localparam logic [2:0] OP_NOP     = 3'd0;
  localparam logic [2:0] OP_ILLEGAL = 3'd7;

  localparam int ST_BUSY    = 0;
  localparam int ST_DONE    = 1;
  localparam int ST_ERROR   = 2;
  localparam int ST_TIMEOUT = 3;

  localparam int GO_BIT  = 5;
  localparam int OPC_MSB = 4;
  localparam int OPC_LSB = 2;

  typedef enum logic [1:0] {
    S_IDLE      = 2'd0,
    S_ISSUE     = 2'd1,
    S_WAIT_DONE = 2'd2,
    S_DONE      = 2'd3
  } state_t;

  // Size codes 0..3 map to matrix dimensions 2..5.
  function automatic logic [2:0] decode_size(input logic [1:0] code);
    return {1'b0, code} + 3'd2;
  endfunction

endpackage

// File: rtl/soc_instr_timeout_cnt.sv
// Completion timeout counter.
// Ports:
//   clk, reset : clock, synchronous active-high reset
//   clr        : load zero
//   en         : count one cycle
//   expired    : count has reached TIMEOUT_CYCLES-1
module soc_instr_timeout_cnt #(
  parameter int TIMEOUT_CYCLES = 1000000
) (
  input  logic clk,
  input  logic reset,
  input  logic clr,
  input  logic en,
  output logic expired
);

  localparam int W = $clog2(TIMEOUT_CYCLES);
  localparam logic [W-1:0] TERM = W'(TIMEOUT_CYCLES - 1);

  logic [W-1:0] cnt;

  // Saturates at the terminal value so a stalled enable cannot wrap.
  always_ff @(posedge clk) begin
    if (reset || clr) begin
      cnt <= '0;
    end else if (en && !expired) begin
      cnt <= cnt + W'(1);
    end
  end

  assign expired = (cnt == TERM);

endmodule

// File: rtl/soc_instruction_receiver.sv
// Receives the 6-bit HPS instruction word, issues one command to the
// matrix datapath over valid/ready and tracks completion with a timeout.
// Ports:
//   clk, reset          : clock, synchronous active-high reset
//   instr_in[5:0]       : {go, opcode[2:0], size_code[1:0]}
//   op_valid/op_ready   : command handshake to the datapath
//   op_code, op_size    : latched opcode and decoded dimension (2..5)
//   exec_done           : completion pulse from the datapath
//   status_out[3:0]     : {timeout, error, done, busy}
//
// state       | meaning
// S_IDLE      | waiting for a go rising edge
// S_ISSUE     | op_valid high, waiting for op_ready
// S_WAIT_DONE | command accepted, waiting for exec_done or timeout
// S_DONE      | result posted, waiting for go to drop
module soc_instruction_receiver
  import soc_instr_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 1000000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] instr_in,
  output logic       op_valid,
  output logic [2:0] op_code,
  output logic [2:0] op_size,
  input  logic       op_ready,
  input  logic       exec_done,
  output logic [3:0] status_out
);

  state_t     state, state_nxt;
  logic       go_q;
  logic       go_rise;
  logic       expired;
  logic [2:0] opc_in;
  logic [3:0] status_q;

  assign opc_in  = instr_in[OPC_MSB:OPC_LSB];
  assign go_rise = instr_in[GO_BIT] & ~go_q;

  soc_instr_timeout_cnt #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_timeout_cnt (
    .clk     (clk),
    .reset   (reset),
    .clr     ((state == S_ISSUE) && op_ready),
    .en      (state == S_WAIT_DONE),
    .expired (expired)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: begin
        if (go_rise) begin
          if (opc_in == OP_NOP || opc_in == OP_ILLEGAL) begin
            state_nxt = S_DONE;
          end else begin
            state_nxt = S_ISSUE;
          end
        end
      end
      S_ISSUE: begin
        if (op_ready) state_nxt = S_WAIT_DONE;
      end
      S_WAIT_DONE: begin
        if (exec_done || expired) state_nxt = S_DONE;
      end
      S_DONE: begin
        if (!instr_in[GO_BIT]) state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // go_q resets high so a go line already high at reset release is not an edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      go_q     <= 1'b1;
      op_valid <= 1'b0;
      op_code  <= '0;
      op_size  <= '0;
      status_q <= '0;
    end else begin
      go_q     <= instr_in[GO_BIT];
      op_valid <= (state_nxt == S_ISSUE);
      case (state)
        S_IDLE: begin
          if (go_rise) begin
            op_code  <= opc_in;
            op_size  <= decode_size(instr_in[1:0]);
            status_q <= 4'b0001;
          end
        end
        S_WAIT_DONE: begin
          // exec_done takes priority over a same-cycle timeout.
          if (exec_done) begin
            status_q <= 4'b0010;
          end else if (expired) begin
            status_q <= 4'b1110;
          end
        end
        S_DONE: begin
          // NOP/ILLEGAL post their result here, one cycle after busy.
          status_q[ST_BUSY] <= 1'b0;
          status_q[ST_DONE] <= 1'b1;
          if (op_code == OP_ILLEGAL) status_q[ST_ERROR] <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign status_out = status_q;

endmodule

// File: tb/tb_soc_instruction_receiver.sv
module tb_soc_instruction_receiver;

  localparam int T = 16;

  logic       clk = 1'b0;
  logic       reset;
  logic [5:0] instr_in;
  logic       op_valid;
  logic [2:0] op_code;
  logic [2:0] op_size;
  logic       op_ready;
  logic       exec_done;
  logic [3:0] status_out;

  int checks = 0;
  int errors = 0;

  soc_instruction_receiver #(.TIMEOUT_CYCLES(T)) dut (
    .clk        (clk),
    .reset      (reset),
    .instr_in   (instr_in),
    .op_valid   (op_valid),
    .op_code    (op_code),
    .op_size    (op_size),
    .op_ready   (op_ready),
    .exec_done  (exec_done),
    .status_out (status_out)
  );

  always #5 clk = ~clk;

  initial begin
    #3000000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Reference: valid opcodes hold op_valid for rd+1 cycles; completion at
  // WAIT_DONE cycle e (e in 0..T-1) posts 0010 one cycle later, otherwise a
  // timeout posts 1110 T cycles after acceptance. NOP posts 0010, ILLEGAL 0110,
  // one cycle after the busy cycle. Results are sticky until the next go.
  task automatic run_cmd(input logic [2:0] opc, input logic [1:0] sz,
                         input int rd, input int e, input bit glitch);
    logic [3:0] exp_st;
    logic [2:0] exp_size;
    int nv;
    int done_tick;
    bit to;
    exp_size = {1'b0, sz} + 3'd2;
    instr_in = {1'b1, opc, sz};
    op_ready = 1'b0;
    tick;
    checks++;
    if (status_out !== 4'b0001) begin
      errors++;
      $display("FAIL busy_start opc=%0d got %b want 0001", opc, status_out);
    end
    if (opc == 3'd0 || opc == 3'd7) begin
      exp_st = (opc == 3'd7) ? 4'b0110 : 4'b0010;
      checks++;
      if (op_valid !== 1'b0) begin
        errors++;
        $display("FAIL no_valid opc=%0d got %b want 0", opc, op_valid);
      end
      tick;
      checks++;
      if (status_out !== exp_st || op_valid !== 1'b0) begin
        errors++;
        $display("FAIL nop_ill_status opc=%0d got %b/%b want %b/0", opc, status_out, op_valid, exp_st);
      end
    end else begin
      nv = 0;
      while (op_valid === 1'b1 && nv < 50) begin
        checks++;
        if (op_code !== opc || op_size !== exp_size) begin
          errors++;
          $display("FAIL fields got %0d/%0d want %0d/%0d", op_code, op_size, opc, exp_size);
        end
        nv++;
        op_ready = (nv > rd);
        tick;
      end
      op_ready = 1'b0;
      checks++;
      if (nv !== rd + 1) begin
        errors++;
        $display("FAIL valid_len got %0d want %0d", nv, rd + 1);
      end
      to = !(e >= 0 && e <= T - 1);
      done_tick = to ? T : e + 1;
      exp_st = to ? 4'b1110 : 4'b0010;
      for (int j = 0; j <= done_tick; j++) begin
        checks++;
        if (j < done_tick) begin
          if (status_out !== 4'b0001 || op_valid !== 1'b0) begin
            errors++;
            $display("FAIL wait_busy j=%0d got %b/%b want 0001/0", j, status_out, op_valid);
          end
          exec_done = (j == e);
          if (glitch && j == 1) instr_in[5] = 1'b0;
          if (glitch && j == 2) instr_in[5] = 1'b1;
          tick;
        end else begin
          if (status_out !== exp_st) begin
            errors++;
            $display("FAIL final_status e=%0d got %b want %b", e, status_out, exp_st);
          end
          exec_done = (e >= done_tick);
        end
      end
    end
    tick;
    exec_done = 1'b0;
    instr_in[5] = 1'b1;
    tick;
    checks++;
    if (status_out !== exp_st || op_valid !== 1'b0) begin
      errors++;
      $display("FAIL done_hold got %b/%b want %b/0", status_out, op_valid, exp_st);
    end
    instr_in = {1'b0, 5'($urandom)};
    op_ready = 1'($urandom);
    tick;
    tick;
    op_ready = 1'b0;
    checks++;
    if (status_out !== exp_st || op_valid !== 1'b0) begin
      errors++;
      $display("FAIL sticky_idle got %b/%b want %b/0", status_out, op_valid, exp_st);
    end
  endtask

  task automatic test_reset;
    reset = 1'b1;
    instr_in = 6'b100101;
    op_ready = 1'b0;
    exec_done = 1'b0;
    repeat (3) tick;
    checks++;
    if (status_out !== 4'b0000 || op_valid !== 1'b0 || op_code !== 3'd0 || op_size !== 3'd0) begin
      errors++;
      $display("FAIL reset_values got st=%b v=%b c=%0d s=%0d want 0", status_out, op_valid, op_code, op_size);
    end
    reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick;
      checks++;
      if (status_out !== 4'b0000 || op_valid !== 1'b0) begin
        errors++;
        $display("FAIL go_high_at_release got %b/%b want 0000/0", status_out, op_valid);
      end
    end
    instr_in[5] = 1'b0;
    tick;
    run_cmd(3'd1, 2'd1, 0, 3, 1'b0);
  endtask

  task automatic test_basic;
    instr_in = 6'b000000;
    tick;
    run_cmd(3'd3, 2'd2, 0, 10, 1'b0);
  endtask

  task automatic test_ready_stall;
    run_cmd(3'd2, 2'd1, 5, 3, 1'b0);
  endtask

  task automatic test_nop_illegal;
    run_cmd(3'd7, 2'd0, 0, 0, 1'b0);
    run_cmd(3'd0, 2'd3, 0, 0, 1'b0);
  endtask

  task automatic test_timeout;
    run_cmd(3'd4, 2'd2, 0, -1, 1'b0);
    run_cmd(3'd5, 2'd0, 1, T - 1, 1'b0);
    run_cmd(3'd6, 2'd3, 0, T, 1'b0);
    run_cmd(3'd1, 2'd1, 2, T - 2, 1'b0);
  endtask

  task automatic test_go_glitch;
    run_cmd(3'd2, 2'd2, 0, 8, 1'b1);
    run_cmd(3'd3, 2'd0, 1, -1, 1'b1);
  endtask

  task automatic test_reset_mid;
    instr_in = {1'b1, 3'd2, 2'd3};
    tick;
    op_ready = 1'b1;
    tick;
    op_ready = 1'b0;
    tick;
    tick;
    checks++;
    if (status_out !== 4'b0001) begin
      errors++;
      $display("FAIL pre_reset_busy got %b want 0001", status_out);
    end
    reset = 1'b1;
    tick;
    reset = 1'b0;
    checks++;
    if (status_out !== 4'b0000 || op_valid !== 1'b0) begin
      errors++;
      $display("FAIL mid_reset got %b/%b want 0000/0", status_out, op_valid);
    end
    exec_done = 1'b1;
    tick;
    exec_done = 1'b0;
    repeat (3) tick;
    checks++;
    if (status_out !== 4'b0000 || op_valid !== 1'b0) begin
      errors++;
      $display("FAIL late_exec got %b/%b want 0000/0", status_out, op_valid);
    end
    instr_in[5] = 1'b0;
    tick;
  endtask

  task automatic test_random;
    logic [2:0] opc;
    logic [1:0] sz;
    int rd;
    int e;
    bit gl;
    for (int i = 0; i < 30; i++) begin
      opc = 3'($urandom_range(0, 7));
      sz  = 2'($urandom_range(0, 3));
      rd  = int'($urandom_range(0, 4));
      e   = int'($urandom_range(0, T + 3)) - 1;
      gl  = (e > 4) ? 1'($urandom_range(0, 1)) : 1'b0;
      run_cmd(opc, sz, rd, e, gl);
    end
  endtask

  initial begin
    test_reset;
    test_basic;
    test_ready_stall;
    test_nop_illegal;
    test_timeout;
    test_go_glitch;
    test_reset_mid;
    test_random;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
